// File: rtl/i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : i2s_tx_serializer
// Brief   : I2S slave transmitter; buffers one stereo frame and shifts it
//           MSB-first onto sd, timed by external sck/ws. Define
//           I2S_TX_ZERO_FILL_EN to transmit zeros on underrun instead of
//           repeating the last frame.
// Revision: 1.0 - initial release
// ============================================================================
module i2s_tx_serializer #(
    parameter int WIDTH = 24
) (
    input  logic             sck,
    input  logic             reset,
    input  logic             ws,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sd,
    output logic             underrun,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             ws_q;
    logic [WIDTH-1:0] pend_l_q, pend_l_d;
    logic [WIDTH-1:0] pend_r_q, pend_r_d;
    logic             pend_full_q, pend_full_d;
    logic [WIDTH-1:0] act_l_q, act_l_d;
    logic [WIDTH-1:0] act_r_q, act_r_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    count_q, count_d;
    logic             sd_q, sd_d;
    logic             busy_q, busy_d;
    logic             underrun_q, underrun_d;

    logic             ws_edge;
    logic             left_start;
    logic             accept;
    logic [WIDTH-1:0] load_word;

    always_comb begin
        ws_edge    = ws ^ ws_q;
        left_start = ws_edge & ~ws;
        in_ready   = ~pend_full_q | left_start;
        accept     = in_valid & in_ready;

        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        pend_full_d = pend_full_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        shift_d     = shift_q;
        count_d     = count_q;
        sd_d        = sd_q;
        busy_d      = busy_q;
        underrun_d  = underrun_q;

        // A refill on the consuming edge keeps the buffer full with the new frame.
        if (accept) begin
            pend_l_d    = in_left;
            pend_r_d    = in_right;
            pend_full_d = 1'b1;
        end else if (left_start) begin
            pend_full_d = 1'b0;
        end

        if (left_start) begin
            if (pend_full_q) begin
                act_l_d = pend_l_q;
                act_r_d = pend_r_q;
            end else begin
                underrun_d = 1'b1;
`ifdef I2S_TX_ZERO_FILL_EN
                act_l_d = '0;
                act_r_d = '0;
`endif
            end
        end

        load_word = left_start ? act_l_d : act_r_q;

        if (ws_edge) begin
            sd_d    = load_word[WIDTH-1];
            shift_d = load_word << 1;
            count_d = CW'(WIDTH - 1);
            busy_d  = 1'b1;
        end else if (count_q != '0) begin
            sd_d    = shift_q[WIDTH-1];
            shift_d = shift_q << 1;
            count_d = count_q - CW'(1);
            busy_d  = (count_q > CW'(1));
        end else begin
            sd_d   = 1'b0;
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge sck or negedge reset) begin
        if (!reset) begin
            ws_q        <= 1'b0;
            pend_l_q    <= '0;
            pend_r_q    <= '0;
            pend_full_q <= 1'b0;
            act_l_q     <= '0;
            act_r_q     <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            sd_q        <= 1'b0;
            busy_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            ws_q        <= ws;
            pend_l_q    <= pend_l_d;
            pend_r_q    <= pend_r_d;
            pend_full_q <= pend_full_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
            shift_q     <= shift_d;
            count_q     <= count_d;
            sd_q        <= sd_d;
            busy_q      <= busy_d;
            underrun_q  <= underrun_d;
        end
    end

    assign sd       = sd_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2s_tx_serializer
// Brief   : Self-checking bench; frame/bit-queue reference model of the I2S
//           transmitter, directed scenarios followed by random slots.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2s_tx_serializer;

    localparam int W = 24;

    typedef struct packed {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } frame_t;

    logic         sck;
    logic         reset;
    logic         ws;
    logic [W-1:0] in_left;
    logic [W-1:0] in_right;
    logic         in_valid;
    logic         in_ready;
    logic         sd;
    logic         underrun;
    logic         busy;

    i2s_tx_serializer #(.WIDTH(W)) dut (
        .sck      (sck),
        .reset    (reset),
        .ws       (ws),
        .in_left  (in_left),
        .in_right (in_right),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sd       (sd),
        .underrun (underrun),
        .busy     (busy)
    );

    initial begin
        sck = 1'b0;
        forever #5 sck = ~sck;
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: frames offered, one pending slot, active frame, bits left in slot.
    frame_t       tx_q[$];
    frame_t       m_pend[$];
    logic [W-1:0] m_act_l, m_act_r;
    logic         m_ws, m_under;
    logic         bitq[$];

    // Capture of the serial stream per slot (first W bits).
    logic [W-1:0] rx_acc, last_l, last_r;
    int           rx_len;
    logic         cap_ws;
    logic [W-1:0] rx_left_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        bitq.delete();
        m_act_l = '0;
        m_act_r = '0;
        m_ws    = 1'b0;
        m_under = 1'b0;
    endtask

    task automatic cycle(input logic wsv);
        logic         m_edge, m_left, m_ready, m_acc, exp_sd;
        logic [W-1:0] word;
        frame_t       f;
        @(negedge sck);
        ws = wsv;
        if (tx_q.size() > 0) begin
            in_valid = 1'b1;
            in_left  = tx_q[0].l;
            in_right = tx_q[0].r;
        end else begin
            in_valid = 1'b0;
            in_left  = W'($urandom);
            in_right = W'($urandom);
        end
        #1;
        m_edge  = (wsv != m_ws);
        m_left  = m_edge && !wsv;
        m_ready = (m_pend.size() == 0) || m_left;
        check("in_ready", 32'(in_ready), 32'(m_ready));
        m_acc = in_valid && m_ready;
        @(posedge sck);
        m_ws = wsv;
        if (m_left) begin
            if (m_pend.size() > 0) begin
                f = m_pend.pop_front();
                m_act_l = f.l;
                m_act_r = f.r;
            end else begin
                m_under = 1'b1;
`ifdef I2S_TX_ZERO_FILL_EN
                m_act_l = '0;
                m_act_r = '0;
`endif
            end
        end
        if (m_acc) begin
            m_pend.push_back(tx_q.pop_front());
        end
        if (m_edge) begin
            bitq.delete();
            word = wsv ? m_act_r : m_act_l;
            for (int i = W - 1; i >= 0; i--) bitq.push_back(word[i]);
        end
        exp_sd = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
        #1;
        check("sd", 32'(sd), 32'(exp_sd));
        check("busy", 32'(busy), 32'(bitq.size() > 0));
        check("underrun", 32'(underrun), 32'(m_under));
        if (m_edge) begin
            if (cap_ws) last_r = rx_acc;
            else begin
                last_l = rx_acc;
                rx_left_q.push_back(rx_acc);
            end
            rx_acc    = '0;
            rx_acc[0] = sd;
            rx_len    = 1;
            cap_ws    = wsv;
        end else if (rx_len < W) begin
            rx_acc = {rx_acc[W-2:0], sd};
            rx_len++;
        end
    endtask

    task automatic run_slot(input logic wsv, input int len);
        repeat (len) cycle(wsv);
    endtask

    function automatic frame_t mk(input logic [W-1:0] l, input logic [W-1:0] r);
        frame_t f;
        f.l = l;
        f.r = r;
        return f;
    endfunction

    logic [W-1:0] exp_repeat_l;

    initial begin
        reset    = 1'b1;
        ws       = 1'b0;
        in_valid = 1'b0;
        in_left  = '0;
        in_right = '0;
        rx_acc   = '0;
        rx_len   = W;
        cap_ws   = 1'b0;
        last_l   = '0;
        last_r   = '0;
        model_reset();
        #1 reset = 1'b0;
        repeat (3) @(posedge sck);
        #1;
        check("rst_sd", 32'(sd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge sck);
        reset = 1'b1;

        // Basic frame with 32-sck slots, preceded by a right slot before any left.
        tx_q.push_back(mk(24'hA5A5A5, 24'h3C3C3C));
        run_slot(1'b0, 4);
        run_slot(1'b1, 32);
        run_slot(1'b0, 32);
        run_slot(1'b1, 32);
        check("frame_left", 32'(last_l), 32'h00A5A5A5);
        check("left_parity", 32'(^last_l), 32'd0);

        // No data offered: underrun on this left slot.
        run_slot(1'b0, 32);
        check("frame_right", 32'(last_r), 32'h003C3C3C);
        check("right_parity", 32'(^last_r), 32'd0);
        check("underrun_set", 32'(underrun), 32'd1);

        // Back-to-back frames with in_valid held high.
        for (int k = 1; k <= 4; k++) tx_q.push_back(mk(W'(k), W'(24'h100 + k)));
        run_slot(1'b1, 32);
`ifdef I2S_TX_ZERO_FILL_EN
        exp_repeat_l = '0;
`else
        exp_repeat_l = 24'hA5A5A5;
`endif
        check("underrun_left", 32'(last_l), 32'(exp_repeat_l));
        rx_left_q.delete();
        repeat (4) begin
            run_slot(1'b0, 32);
            run_slot(1'b1, 32);
        end
        check("b2b_count", 32'(rx_left_q.size()), 32'd4);
        for (int k = 0; k < 4 && k < rx_left_q.size(); k++)
            check("b2b_order", 32'(rx_left_q[k]), 32'(k + 1));

        // Short 16-sck slots: only the top 16 bits are sent.
        tx_q.push_back(mk(24'hA5A5A5, 24'h3C3C3C));
        run_slot(1'b1, 4);
        run_slot(1'b0, 16);
        run_slot(1'b1, 16);
        check("short_left", 32'(last_l), 32'h0000A5A5);
        run_slot(1'b0, 16);
        check("short_right", 32'(last_r), 32'h00003C3C);
        run_slot(1'b1, 16);

        // Reset asserted in the middle of a left word.
        tx_q.push_back(mk(24'h5A5A5A, 24'h0F0F0F));
        run_slot(1'b1, 4);
        run_slot(1'b0, 10);
        @(negedge sck);
        reset = 1'b0;
        ws    = 1'b0;
        #1;
        check("midrst_sd", 32'(sd), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        model_reset();
        tx_q.delete();
        repeat (2) @(posedge sck);
        @(negedge sck);
        reset = 1'b1;
        tx_q.push_back(mk(24'h123456, 24'hABCDEF));
        run_slot(1'b0, 4);
        run_slot(1'b1, 32);
        run_slot(1'b0, 32);
        run_slot(1'b1, 32);
        check("post_rst_left", 32'(last_l), 32'h00123456);
        run_slot(1'b0, 4);
        check("post_rst_right", 32'(last_r), 32'h00ABCDEF);
        run_slot(1'b1, 28);

        // Random frames, offer gaps and slot lengths.
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) != 0 && tx_q.size() < 2)
                tx_q.push_back(mk(W'($urandom), W'($urandom)));
            run_slot(1'b0, int'($urandom_range(8, 34)));
            run_slot(1'b1, int'($urandom_range(8, 34)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2s_tx_serializer.md
Name: i2s_tx_serializer

Overview:
- I2S slave transmitter. Sits directly upstream of the I2S receiver stage and drives its `sd` line.
- Accepts stereo sample pairs on a valid/ready parallel interface and buffers one pending frame.
- Serializes the pair MSB-first onto `sd`, timed by the externally supplied `sck`/`ws`.
- Used as the on-chip loopback source and as the stimulus generator for the receiver.

Parameters:
- WIDTH, 24, bits per channel word. Must match the receiver's WIDTH.

Ports:
- sck  input  1  bit clock; all logic on posedge sck
- reset  input  1  asynchronous, active-low reset
- ws  input  1  word select from the bus master; 0 = left, 1 = right
- in_left  input  WIDTH  left sample of offered frame
- in_right  input  WIDTH  right sample of offered frame
- in_valid  input  1  frame offered
- in_ready  output  1  frame accepted when in_valid & in_ready at posedge
- sd  output  1  serial data, registered
- underrun  output  1  sticky flag: a left slot started with no pending frame
- busy  output  1  shift register holds bits still to send

Behaviour:
- Reset (reset=0, async):
  - sd=0, underrun=0, busy=0, in_ready=1
  - ws_q=0, pending empty, active_left/active_right/shift/count cleared
- Edge detect:
  - ws_q <= ws every posedge; edge = ws ^ ws_q (combinational).
  - The MSB appears on `sd` at the posedge after edge is seen, which is the one-sck I2S delay relative to the registered ws.
- Pending buffer (one frame):
  - Accept on in_valid & in_ready: latch in_left/in_right, set pending_full.
  - in_ready = !pending_full | left_start, where left_start = edge & !ws.
  - Simultaneous accept and consume in the same cycle: the new frame becomes pending and the old one moves to active. No loss, no stall.
- Left slot start (left_start):
  - If pending_full: active_left/active_right <= pending frame; clear pending_full unless refilled in the same cycle.
  - Else: set underrun (sticky until reset); active regs handled per the Optional Feature.
  - Load: shift <= word << 1, sd <= word[WIDTH-1], count <= WIDTH-1, busy=1.
  - The word loaded is the new active_left; bypass the pending value combinationally on that cycle.
- Right slot start (edge & ws): the same load sequence using active_right. The pending buffer is not touched. The right word always belongs to the same frame as the preceding left word.
- Shift (no edge):
  - If count>0: sd <= shift[WIDTH-1], shift <= shift<<1, count--, busy=(count>1).
  - If count==0: sd <= 0 (pad bits when the slot is longer than WIDTH), busy=0.
- Short slot (edge before count reaches 0): the remaining LSBs are dropped and the new word loads immediately. Not an error; underrun is unaffected.
- First slot after reset:
  - If ws=0 at reset release, no edge occurs until ws goes 1.
  - A right slot that starts before any left slot transmits active_right (0 after reset).
- Reset asserted mid-word: sd goes to 0 immediately; any partial word is lost.

Optional Feature:
- Macro I2S_TX_ZERO_FILL_EN.
- Defined: on underrun, active_left/active_right <= 0, so the whole frame transmits as zeros.
- Undefined: on underrun, active regs keep their previous values and the last frame repeats.
- underrun flag behaviour is identical in both builds.

Test Plan:
- Reset then frame L=0xA5A5A5, R=0x3C3C3C with 32-sck slots:
  - sd carries 101001011010010110100101 MSB-first, starting one sck after the left edge is seen, then 8 zero pads.
  - Right slot carries 0x3C3C3C the same way.
  - Loop into the receiver: its left-parity output=0, right-parity output=0.
- Back-to-back frames with in_valid held high:
  - in_ready drops after the first accept and re-asserts on each left_start.
  - 4 frames 0x000001..0x000004 transmitted in order; none dropped or duplicated.
- Accept coincident with left_start (in_valid rises on the same posedge):
  - Previous pending frame goes out.
  - New frame is held pending and goes out on the next left slot.
- No data after the first frame:
  - underrun=1 at the second left_start.
  - With I2S_TX_ZERO_FILL_EN, sd=0 for the whole frame; without it, 0xA5A5A5/0x3C3C3C repeats.
- Short slots (ws toggles every 16 sck, WIDTH=24): only the upper 16 bits (0xA5A5) are sent per slot, the next word loads cleanly, and busy never deasserts.
- reset pulsed low at bit 10 of the left word: sd=0 and underrun=0 immediately; the next accepted frame transmits fully from the following left edge.
